// File: rtl/branch_resolve_unit.sv
// EX-side branch resolution: in-order queue of IF prediction metadata, checked
// against EX outcomes to train the GShare predictor and redirect on mispredicts.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_push,
    input  logic [31:0]      if_pc,
    input  logic             if_pred_taken,
    input  logic [31:0]      if_pred_target,
    input  logic [IDX_W-1:0] if_pht_idx,
    output logic             q_full,
    input  logic             ex_resolve,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             flush,
    output logic             ex_update_en,
    output logic             ex_actual_taken,
    output logic [IDX_W-1:0] pht_idx_ex,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic             err_overflow,
    output logic             err_underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

    logic [31:0]      pc_mem     [DEPTH];
    logic             taken_mem  [DEPTH];
    logic [31:0]      target_mem [DEPTH];
    logic [IDX_W-1:0] idx_mem    [DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;

    logic do_pop, mispredict, drop_all, push_ok, overflow, underflow;
    logic [31:0] e_pc, e_target;
    logic        e_taken;

    assign q_full   = (count == FULL);
    assign e_pc     = pc_mem[rd_ptr];
    assign e_taken  = taken_mem[rd_ptr];
    assign e_target = target_mem[rd_ptr];

    always_comb begin
        do_pop     = ex_resolve && (count != '0);
        mispredict = do_pop && ((e_taken != ex_taken) || (ex_taken && (e_target != ex_target)));
        drop_all   = flush || mispredict;
        // A pop in the same cycle frees a slot, so a push onto a full queue still fits.
        push_ok    = if_push && !drop_all && (!q_full || do_pop);
        overflow   = if_push && !drop_all && q_full && !do_pop;
        underflow  = ex_resolve && (count == '0);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[wr_ptr]     <= if_pc;
            taken_mem[wr_ptr]  <= if_pred_taken;
            target_mem[wr_ptr] <= if_pred_target;
            idx_mem[wr_ptr]    <= if_pht_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (drop_all) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !do_pop)      count <= count + CNT_ONE;
            else if (!push_ok && do_pop) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_update_en    <= 1'b0;
            ex_actual_taken <= 1'b0;
            pht_idx_ex      <= '0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
            branch_cnt      <= '0;
            mispred_cnt     <= '0;
            err_overflow    <= 1'b0;
            err_underflow   <= 1'b0;
        end else begin
            ex_update_en   <= do_pop;
            redirect_valid <= mispredict && !flush;
            if (do_pop) begin
                ex_actual_taken <= ex_taken;
                pht_idx_ex      <= idx_mem[rd_ptr];
                branch_cnt      <= branch_cnt + STAT_ONE;
            end
            if (mispredict) mispred_cnt <= mispred_cnt + STAT_ONE;
            // An external flush owns the front end, so its redirect wins over ours.
            if (mispredict && !flush) redirect_pc <= ex_taken ? ex_target : e_pc + 32'd4;
            if (overflow)  err_overflow  <= 1'b1;
            if (underflow) err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus random bench for branch_resolve_unit against a queue-based
// model of in-flight predictions.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int IDX_W = 8;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             if_push = 1'b0;
    logic [31:0]      if_pc = '0;
    logic             if_pred_taken = 1'b0;
    logic [31:0]      if_pred_target = '0;
    logic [IDX_W-1:0] if_pht_idx = '0;
    logic             q_full;
    logic             ex_resolve = 1'b0;
    logic             ex_taken = 1'b0;
    logic [31:0]      ex_target = '0;
    logic             flush = 1'b0;
    logic             ex_update_en, ex_actual_taken, redirect_valid;
    logic [IDX_W-1:0] pht_idx_ex;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;
    logic             err_overflow, err_underflow;

    branch_resolve_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_push(if_push), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .if_pred_target(if_pred_target), .if_pht_idx(if_pht_idx), .q_full(q_full),
        .ex_resolve(ex_resolve), .ex_taken(ex_taken), .ex_target(ex_target), .flush(flush),
        .ex_update_en(ex_update_en), .ex_actual_taken(ex_actual_taken), .pht_idx_ex(pht_idx_ex),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      pc;
        logic             pt;
        logic [31:0]      tg;
        logic [IDX_W-1:0] idx;
    } ent_t;

    ent_t mq[$];
    int vectors = 0;
    int miscompares = 0;

    logic             m_upd, m_at, m_rv, m_ovf, m_unf;
    logic [IDX_W-1:0] m_idx;
    logic [31:0]      m_rpc;
    logic [CNT_W-1:0] m_bc, m_mc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_upd = 0; m_at = 0; m_rv = 0; m_ovf = 0; m_unf = 0;
        m_idx = '0; m_rpc = '0; m_bc = '0; m_mc = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".upd"}, 64'(ex_update_en), 64'(m_upd));
        chk({tag, ".at"},  64'(ex_actual_taken), 64'(m_at));
        chk({tag, ".idx"}, 64'(pht_idx_ex), 64'(m_idx));
        chk({tag, ".rv"},  64'(redirect_valid), 64'(m_rv));
        chk({tag, ".rpc"}, 64'(redirect_pc), 64'(m_rpc));
        chk({tag, ".bc"},  64'(branch_cnt), 64'(m_bc));
        chk({tag, ".mc"},  64'(mispred_cnt), 64'(m_mc));
        chk({tag, ".ovf"}, 64'(err_overflow), 64'(m_ovf));
        chk({tag, ".unf"}, 64'(err_underflow), 64'(m_unf));
    endtask

    // One clock: drive inputs, predict with the model, check after the edge.
    task automatic step(input string tag,
                        input logic p, input logic [31:0] pc, input logic pt,
                        input logic [31:0] ptg, input logic [IDX_W-1:0] idx,
                        input logic r, input logic tk, input logic [31:0] tg,
                        input logic fl);
        ent_t e, n;
        logic mis;
        int sz;
        if_push = p; if_pc = pc; if_pred_taken = pt; if_pred_target = ptg; if_pht_idx = idx;
        ex_resolve = r; ex_taken = tk; ex_target = tg; flush = fl;
        #1;
        sz = mq.size();
        chk({tag, ".full"}, 64'(q_full), 64'(sz == DEPTH));
        mis = 0;
        m_upd = 0; m_rv = 0;
        if (r && sz == 0) m_unf = 1;
        if (r && sz > 0) begin
            e = mq.pop_front();
            mis = (e.pt != tk) || (tk && e.tg != tg);
            m_upd = 1; m_at = tk; m_idx = e.idx; m_bc = m_bc + 1;
            if (mis) begin
                m_mc = m_mc + 1;
                if (!fl) begin
                    m_rv = 1;
                    m_rpc = tk ? tg : e.pc + 32'd4;
                end
            end
        end
        if (fl || mis) mq.delete();
        else if (p) begin
            if (sz < DEPTH || (r && sz > 0)) begin
                n.pc = pc; n.pt = pt; n.tg = ptg; n.idx = idx;
                mq.push_back(n);
            end else m_ovf = 1;
        end
        @(posedge clk); #1;
        if_push = 0; ex_resolve = 0; flush = 0;
        check_all(tag);
    endtask

    task automatic push(input string tag, input logic [31:0] pc, input logic pt,
                        input logic [31:0] ptg, input logic [IDX_W-1:0] idx);
        step(tag, 1, pc, pt, ptg, idx, 0, 0, 0, 0);
    endtask

    task automatic resolve(input string tag, input logic tk, input logic [31:0] tg);
        step(tag, 0, 0, 0, 0, 0, 1, tk, tg, 0);
    endtask

    initial begin
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.full", 64'(q_full), 64'(0));
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        push("t1.push", 32'h100, 0, 32'h0, 8'h40);
        resolve("t1.res", 0, 32'h0);

        push("t2.push", 32'h200, 0, 32'h0, 8'h11);
        resolve("t2.res", 1, 32'h300);

        push("t3.push", 32'h400, 1, 32'h500, 8'h22);
        resolve("t3.res", 1, 32'h600);
        push("t3b.push", 32'hFFFF_FFFC, 1, 32'h700, 8'h23);
        resolve("t3b.res", 0, 32'h0);

        // Fill, overflow, then drain across the pointer wrap.
        for (int i = 0; i < DEPTH; i++)
            push("t4.fill", 32'h1000 + 32'(i * 4), 0, 32'h0, 8'(8'h50 + i));
        push("t4.ovf", 32'h2000, 0, 32'h0, 8'h99);
        for (int i = 0; i < DEPTH; i++) resolve("t4.drain", 0, 32'h0);

        for (int i = 0; i < 3; i++)
            push("t5.fill", 32'h3000 + 32'(i * 4), 1, 32'h3800, 8'(8'h60 + i));
        step("t5.mis", 1, 32'h4000, 0, 32'h0, 8'h77, 1, 1, 32'h3900, 0);
        resolve("t5.unf", 0, 32'h0);

        push("t6.fill", 32'h5000, 0, 32'h0, 8'h81);
        push("t6.fill", 32'h5004, 0, 32'h0, 8'h82);
        step("t6.flush", 1, 32'h6000, 0, 32'h0, 8'h83, 1, 1, 32'h5100, 1);
        chk("t6.full", 64'(q_full), 64'(0));

        push("t7.push", 32'h7000, 0, 32'h0, 8'h91);
        step("t7.res", 0, 0, 0, 0, 0, 1, 1, 32'h7100, 0);
        #2 rst = 1;
        #1;
        model_reset();
        check_all("t7.rst");
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        for (int k = 0; k < 400; k++) begin
            logic [31:0] tset [4];
            tset[0] = 32'h1000; tset[1] = 32'h2000; tset[2] = 32'h3000; tset[3] = 32'h4000;
            step("rand",
                 ($urandom_range(0, 9) < 6), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 1'($urandom_range(0, 1)), tset[$urandom_range(0, 1)], 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) < 5), 1'($urandom_range(0, 1)), tset[$urandom_range(0, 1)],
                 ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
